// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive-path types and constants
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ODD  = 2'd1,
        EVEN = 2'd2
    } parity_mode_e;

    // One stored receive entry: parity-error flag alongside the byte.
    typedef struct packed {
        logic                   perr;
        logic [UART_DATA_W-1:0] data;
    } uart_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - DEPTH x 9 simple dual-port storage, sync write, async read
//
// Ports:
//   aclk      clock for the write port
//   we_i      write enable
//   waddr_i   write address
//   wdata_i   entry to write
//   raddr_i   read address
//   rdata_o   entry at raddr_i (combinational)
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          aclk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  uart_entry_t   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output uart_entry_t   rdata_o
);

    // No reset: pointers in the parent decide which entries are meaningful.
    uart_entry_t mem_q [DEPTH];

    always_ff @(posedge aclk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_axis_fifo.sv
// rtl/uart_rx_axis_fifo.sv - UART receive byte FIFO with stream output and drop status
//
// Parameters:
//   DEPTH            entries, power of two in 4..256
//   DROP_PARITY_ERR  1: discard bytes flagged with s_tuser, 0: store them with the flag
// Ports:
//   aclk, aresetn    clock, synchronous active-low reset
//   s_tdata/s_tuser/s_tvalid   incoming byte, parity-error flag, single-cycle strobe
//   m_tdata/m_tuser/m_tvalid/m_tready   head-of-FIFO byte stream
//   level            occupancy 0..DEPTH
//   overflow         sticky: a byte was lost to a full FIFO
//   drop_count       saturating count of all discarded bytes
//   clr_status       clears overflow and drop_count
module uart_rx_axis_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH           = 16,
    parameter bit DROP_PARITY_ERR = 1'b0
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [UART_DATA_W-1:0]   s_tdata,
    input  logic                     s_tuser,
    input  logic                     s_tvalid,
    output logic [UART_DATA_W-1:0]   m_tdata,
    output logic                     m_tuser,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    input  logic                     clr_status
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        overflow_q, overflow_d;
    logic [15:0] drop_count_q, drop_count_d;

    logic        empty;
    logic        full;
    logic        parity_drop;
    logic        push;
    logic        pop;
    logic        ovf_event;
    logic        drop_event;
    uart_entry_t wr_entry;
    uart_entry_t rd_entry;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // A flagged byte in drop mode is a parity drop even when the FIFO is full,
    // so it never raises overflow.
    assign parity_drop = s_tvalid && DROP_PARITY_ERR && s_tuser;
    assign push        = s_tvalid && !full && !parity_drop;
    assign pop         = !empty && m_tready;
    assign ovf_event   = s_tvalid && full && !parity_drop;
    assign drop_event  = s_tvalid && !push;

    assign wr_entry.perr = s_tuser;
    assign wr_entry.data = s_tdata;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .aclk    (aclk),
        .we_i    (push),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rd_entry)
    );

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // Clear first, then apply this cycle's event so a drop coincident
        // with clr_status is still recorded.
        if (clr_status) begin
            overflow_d   = 1'b0;
            drop_count_d = 16'd0;
        end
        if (ovf_event) begin
            overflow_d = 1'b1;
        end
        if (drop_event && (drop_count_d != 16'hFFFF)) begin
            drop_count_d = drop_count_d + 16'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= 16'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign m_tdata    = rd_entry.data;
    assign m_tuser    = rd_entry.perr;
    assign m_tvalid   = !empty;
    assign level      = wr_ptr_q - rd_ptr_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_uart_rx_axis_fifo.sv
// tb/tb_uart_rx_axis_fifo.sv - directed self-checking bench for uart_rx_axis_fifo
module tb_uart_rx_axis_fifo;

    logic        aclk;
    logic        aresetn;
    logic [7:0]  s_tdata;
    logic        s_tuser;
    logic        s_tvalid;
    logic        m_tready;
    logic        clr_status;

    // Instance a: store flagged bytes; instance b: drop flagged bytes.
    logic [7:0]  a_tdata,  b_tdata;
    logic        a_tuser,  b_tuser;
    logic        a_tvalid, b_tvalid;
    logic [4:0]  a_level,  b_level;
    logic        a_ovf,    b_ovf;
    logic [15:0] a_drop,   b_drop;

    int n_cmp = 0;
    int n_err = 0;

    uart_rx_axis_fifo #(.DEPTH(16), .DROP_PARITY_ERR(1'b0)) dut_a (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s_tdata    (s_tdata),
        .s_tuser    (s_tuser),
        .s_tvalid   (s_tvalid),
        .m_tdata    (a_tdata),
        .m_tuser    (a_tuser),
        .m_tvalid   (a_tvalid),
        .m_tready   (m_tready),
        .level      (a_level),
        .overflow   (a_ovf),
        .drop_count (a_drop),
        .clr_status (clr_status)
    );

    uart_rx_axis_fifo #(.DEPTH(16), .DROP_PARITY_ERR(1'b1)) dut_b (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s_tdata    (s_tdata),
        .s_tuser    (s_tuser),
        .s_tvalid   (s_tvalid),
        .m_tdata    (b_tdata),
        .m_tuser    (b_tuser),
        .m_tvalid   (b_tvalid),
        .m_tready   (m_tready),
        .level      (b_level),
        .overflow   (b_ovf),
        .drop_count (b_drop),
        .clr_status (clr_status)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 ns after it.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic u);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tuser  = u;
        step();
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
    endtask

    initial begin
        aresetn    = 1'b0;
        s_tdata    = 8'h00;
        s_tuser    = 1'b0;
        s_tvalid   = 1'b0;
        m_tready   = 1'b0;
        clr_status = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_tvalid", a_tvalid, 0);
        chk("rst_level",  a_level,  0);
        chk("rst_ovf",    a_ovf,    0);
        chk("rst_drop",   a_drop,   0);
        aresetn = 1'b1;

        // Three bytes held, then drained on consecutive cycles
        push(8'h41, 1'b0);
        chk("fwft_tvalid", a_tvalid, 1);
        chk("fwft_tdata",  a_tdata,  8'h41);
        chk("fwft_level",  a_level,  1);
        push(8'h42, 1'b0);
        push(8'h43, 1'b0);
        chk("hold_level", a_level, 3);
        step();
        chk("hold_tdata", a_tdata, 8'h41);
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("drain_tdata", a_tdata, 8'h41 + i);
            chk("drain_level", a_level, 3 - i);
            step();
        end
        chk("drain_tvalid", a_tvalid, 0);
        chk("drain_level0", a_level,  0);
        m_tready = 1'b0;

        // Fill to 16, then two more bytes lost
        for (int i = 0; i < 16; i++) push(8'h10 + i, 1'b0);
        chk("full_level",  a_level, 16);
        chk("full_noovf",  a_ovf,   0);
        push(8'h20, 1'b0);
        push(8'h21, 1'b0);
        chk("ovf_level", a_level, 16);
        chk("ovf_flag",  a_ovf,   1);
        chk("ovf_drop",  a_drop,  2);

        // Full, push and pop together: push dropped, pop proceeds
        chk("fullpop_head", a_tdata, 8'h10);
        m_tready = 1'b1;
        push(8'hEE, 1'b0);
        chk("fullpop_level", a_level, 15);
        chk("fullpop_ovf",   a_ovf,   1);
        chk("fullpop_drop",  a_drop,  3);
        for (int i = 1; i < 16; i++) begin
            chk("ovf_seq", a_tdata, 8'h10 + i);
            step();
        end
        chk("ovf_empty", a_tvalid, 0);
        m_tready = 1'b0;

        // Clear status
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        chk("clr_ovf",  a_ovf,  0);
        chk("clr_drop", a_drop, 0);

        // Parity byte arriving with clr_status: dropped in b with count 1
        clr_status = 1'b1;
        push(8'h55, 1'b1);
        clr_status = 1'b0;
        push(8'hAA, 1'b0);
        chk("par_a_level", a_level,  2);
        chk("par_a_tdata", a_tdata,  8'h55);
        chk("par_a_tuser", a_tuser,  1);
        chk("par_a_drop",  a_drop,   0);
        chk("par_b_level", b_level,  1);
        chk("par_b_tdata", b_tdata,  8'hAA);
        chk("par_b_tuser", b_tuser,  0);
        chk("par_b_drop",  b_drop,   1);
        chk("par_b_ovf",   b_ovf,    0);
        m_tready = 1'b1;
        step();
        chk("par_a_tdata2", a_tdata,  8'hAA);
        chk("par_a_tuser2", a_tuser,  0);
        chk("par_b_empty",  b_tvalid, 0);
        step();
        chk("par_a_empty",  a_tvalid, 0);

        // Streaming 40 bytes: pointers wrap, level stays at most 1
        s_tvalid = 1'b1;
        s_tuser  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) begin
                chk("strm_tdata", a_tdata, 8'h80 + i - 1);
            end
            s_tdata = 8'h80 + i;
            step();
            chk("strm_level", a_level, 1);
        end
        s_tvalid = 1'b0;
        chk("strm_last", a_tdata, 8'h80 + 39);
        step();
        chk("strm_empty", a_tvalid, 0);
        m_tready = 1'b0;

        // Reset with 7 stored, then first push accepted immediately
        for (int i = 0; i < 7; i++) push(8'h30 + i, 1'b0);
        chk("pre_rst_level", a_level, 7);
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        chk("midrst_tvalid", a_tvalid, 0);
        chk("midrst_level",  a_level,  0);
        push(8'h7E, 1'b0);
        chk("postrst_tvalid", a_tvalid, 1);
        chk("postrst_tdata",  a_tdata,  8'h7E);
        chk("postrst_level",  a_level,  1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_axis_fifo.md
UART_RX_AXIS_FIFO -- requirements
Module: uart_rx_axis_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, 4..256.
REQ-002 Parameter DROP_PARITY_ERR, default 0: 1 discards incoming bytes with s_tuser=1, 0 stores them with their flag.
REQ-003 aclk  in  1  clock; aresetn  in  1  reset, synchronous, active-low.
REQ-004 s_tdata  in  8  received byte from UART receiver.
REQ-005 s_tuser  in  1  parity-error flag accompanying s_tdata.
REQ-006 s_tvalid  in  1  single-cycle byte strobe; no back-pressure path exists (no s_tready).
REQ-007 m_tdata  out  8  head-of-FIFO byte.
REQ-008 m_tuser  out  1  parity-error flag of head byte.
REQ-009 m_tvalid  out  1  FIFO not empty.
REQ-010 m_tready  in  1  downstream accept.
REQ-011 level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 overflow  out  1  sticky flag, set on any byte lost to a full FIFO.
REQ-013 drop_count  out  16  count of bytes lost (overflow plus parity drops).
REQ-014 clr_status  in  1  synchronous clear of overflow and drop_count.

Function
REQ-015 Storage SHALL hold 9-bit entries {tuser, tdata}, written at wr_ptr, read at rd_ptr; pointers $clog2(DEPTH)+1 bits wide, MSB used to distinguish full from empty.
REQ-016 empty SHALL be wr_ptr==rd_ptr; full SHALL be equal low bits with differing MSB.
REQ-017 Push SHALL occur when s_tvalid=1, full=0, and not (DROP_PARITY_ERR=1 and s_tuser=1).
REQ-018 Pop SHALL occur when m_tvalid=1 and m_tready=1; rd_ptr increments by one, wrapping modulo 2*DEPTH.
REQ-019 Push latency: byte pushed at edge N SHALL present on m_tdata/m_tvalid after edge N (first-word fall-through, one cycle).
REQ-020 m_tdata/m_tuser SHALL be stable while m_tvalid=1 and m_tready=0; undefined values permitted when m_tvalid=0.
REQ-021 Full with s_tvalid=1: byte SHALL be discarded even if a pop occurs in the same cycle; overflow set, drop_count incremented.
REQ-022 Empty with simultaneous s_tvalid: push only; m_tvalid rises next cycle (no bypass).
REQ-023 Simultaneous push and pop when neither full nor empty: both pointers advance, level unchanged.
REQ-024 Parity drop (REQ-002 mode 1) SHALL increment drop_count but SHALL NOT set overflow.
REQ-025 drop_count SHALL saturate at 16'hFFFF.
REQ-026 clr_status=1 SHALL clear overflow and drop_count next edge; a drop event in the same cycle SHALL take priority (overflow=1, drop_count=1 as applicable).
REQ-027 level SHALL equal wr_ptr - rd_ptr, registered-pointer derived, updated same edge as pointers.

Reset
REQ-028 aresetn=0 at a rising edge SHALL set wr_ptr=rd_ptr=0, overflow=0, drop_count=0; hence m_tvalid=0, level=0.
REQ-029 Reset mid-operation SHALL discard all stored bytes; storage array contents need not be cleared.
REQ-030 First push after reset release SHALL be accepted on the first cycle aresetn=1.

Structure
REQ-031 Shared package uart_pkg SHALL hold UART_DATA_W=8, the parity-mode enum (NONE, ODD, EVEN) and the 9-bit entry struct {perr, data}.
REQ-032 Storage SHALL be sub-module uart_fifo_mem: simple dual-port, synchronous write, asynchronous read, DEPTH x 9.
REQ-033 Pointer, flag and status logic SHALL reside in uart_rx_axis_fifo.

Verification
REQ-034 Push 0x41,0x42,0x43 with m_tready=0, then m_tready=1 -> m_tdata 0x41,0x42,0x43 on consecutive cycles, level 3->0, m_tvalid falls after third.
REQ-035 DEPTH=16, push 18 bytes, m_tready=0 -> level=16, overflow=1, drop_count=2, popped sequence equals first 16 bytes.
REQ-036 DROP_PARITY_ERR=1, push 0x55 tuser=1 then 0xAA tuser=0 -> only 0xAA output, drop_count=1, overflow=0; with DROP_PARITY_ERR=0 both output, m_tuser=1 then 0.
REQ-037 Continuous push and pop for 40 bytes with m_tready=1 -> pointers wrap twice, ordering preserved, level never exceeds 1.
REQ-038 Full FIFO, push and pop same cycle -> pushed byte dropped, level 15, overflow=1.
REQ-039 Assert aresetn=0 with level=7, release -> m_tvalid=0, level=0, next push 0x7E appears after one cycle.
